seq_mult_8x8: RTL
=================

SEQ_MULT_8X8 -- requirements
Module: seq_mult_8x8

Interface
REQ-001 SHALL have parameter A_W, default 8, meaning width of operand A; the only legal value is 8.
REQ-002 SHALL have parameter B_W, default 8, meaning width of operand B; the only legal value is 8.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request to begin a multiply.
REQ-006 SHALL have port dataa, input, 8 bits: unsigned multiplicand.
REQ-007 SHALL have port datab, input, 8 bits: unsigned multiplier.
REQ-008 SHALL have port product, output, 16 bits: registered accumulated product.
REQ-009 SHALL have port done, output, 1 bit: product is final.
REQ-010 SHALL have port busy, output, 1 bit: a calculation is in progress.
REQ-011 SHALL have port disp_state, output, 3 bits: step code for the downstream 7-segment encoder.

Function
REQ-012 SHALL implement an FSM with exactly three states: IDLE, CALC and DONE.
REQ-013 SHALL, in IDLE or DONE at a rising edge with start=1, latch dataa and datab, clear product to 0, clear done, set step index to 0 and enter CALC.
REQ-014 SHALL, in CALC, at each edge add one shifted 4x4 partial product to product, in this order:
  - idx0: a[3:0]*b[3:0], shift 0
  - idx1: a[3:0]*b[7:4], shift 4
  - idx2: a[7:4]*b[3:0], shift 4
  - idx3: a[7:4]*b[7:4], shift 8
REQ-015 SHALL perform the accumulation at 16 bits; the final sum never overflows, because 255*255 = 65025.
REQ-016 SHALL, after the idx3 edge, enter DONE with done=1 and the final product; latency is 5 edges counting the start edge.
REQ-017 SHALL hold product and done stable in DONE until the next accepted start.
REQ-018 SHALL ignore start while in CALC, leaving operands and sequence undisturbed.
REQ-019 SHALL use only the latched operands after the start edge, so changes on dataa and datab are ignored.
REQ-020 SHALL drive busy=1 exactly while in CALC.
REQ-021 SHALL drive disp_state to the current idx (3'd0..3'd3) in CALC, and to 3'd4 in IDLE and DONE, which the encoder shows as "E".
REQ-022 SHALL, on start in DONE, restart immediately: done drops on that same edge.

Reset
REQ-023 SHALL, while reset_n=0, immediately force state=IDLE, product=0, done=0, busy=0, disp_state=3'd4, step index=0 and latched operands=0.
REQ-024 SHALL let reset during CALC abort the operation with no residual state; the first start after release behaves as from power-up.
REQ-025 SHALL accept start no earlier than the first rising edge after reset_n deasserts.

Configuration
REQ-026 SHALL, with macro SEQ_MULT_ZERO_SKIP_EN defined, on an accepted start where dataa==0 or datab==0, go directly to DONE on the next edge with product=0 and done=1, without passing through CALC steps.
REQ-027 SHALL, without SEQ_MULT_ZERO_SKIP_EN, treat zero operands like any others, taking the full 4 CALC cycles.

Structure
REQ-028 SHALL place the state encodings, the DISP_END constant (3'd4) and the shift amounts per idx in shared package seq_mult_pkg.
REQ-029 SHALL contain one sub-module, mult_4x4: combinational, 4-bit by 4-bit to 8-bit unsigned, instantiated once with operands muxed by idx.
REQ-030 SHALL be scoped so the implementation totals 120-400 RTL lines including the sub-module.

Verification
REQ-031 SHALL cover: dataa=8'hFF, datab=8'hFF, start pulse -> disp_state 0,1,2,3 on successive cycles, then product=16'hFE01, done=1, disp_state=4.
REQ-032 SHALL cover: dataa=8'd12, datab=8'd10, then start held high in CALC with operands changed to 8'd3 -> product=16'd120, and no restart until DONE.
REQ-033 SHALL cover: reset_n pulled low at idx2 of 8'hA5*8'h5A -> all outputs at reset values immediately; a fresh 8'hA5*8'h5A then gives 16'h3A02.
REQ-034 SHALL cover: dataa=0, datab=8'h37, with the macro defined -> done one edge after start with product=0; without it -> done after 4 CALC cycles with product=0.
REQ-035 SHALL cover: back-to-back start in DONE with 8'h10*8'h10 -> done falls on that edge, and the new result is 16'h0100 four cycles later.
REQ-036 SHALL cover: a random sweep of 1000 operand pairs -> product equals dataa*datab for every pair.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: state encodings, display code and per-step shift amounts
// shared by the sequential 8x8 multiplier.
package seq_mult_pkg;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   localparam logic [2:0] DISP_END = 3'd4;
   localparam logic [3:0] SHIFT0 = 4'd0;
   localparam logic [3:0] SHIFT1 = 4'd4;
   localparam logic [3:0] SHIFT2 = 4'd4;
   localparam logic [3:0] SHIFT3 = 4'd8;
   function automatic logic [3:0] step_shift(input logic [1:0] idx);
      return idx == 2'd0 ? SHIFT0 : idx == 2'd1 ? SHIFT1 : idx == 2'd2 ? SHIFT2 : SHIFT3;
   endfunction
endpackage

// File: rtl/mult_4x4.sv
// mult_4x4: combinational 4x4 -> 8 bit unsigned multiplier.
module mult_4x4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [7:0] p
);
   assign p = a * b;
endmodule

// File: rtl/seq_mult_8x8.sv
// seq_mult_8x8: 8x8 unsigned multiply built from four 4x4 partial products over four cycles.
// Define SEQ_MULT_ZERO_SKIP_EN to finish immediately when either operand is zero.
module seq_mult_8x8
   import seq_mult_pkg::*;
#(
   parameter int A_W = 8,
   parameter int B_W = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic [A_W-1:0]     dataa,
   input  logic [B_W-1:0]     datab,
   output logic [A_W+B_W-1:0] product,
   output logic               done,
   output logic               busy,
   output logic [2:0]         disp_state
);
   state_t state, state_nxt;
   logic [1:0] idx, idx_nxt;
   logic [A_W-1:0] a_q, a_nxt;
   logic [B_W-1:0] b_q, b_nxt;
   logic [A_W+B_W-1:0] product_nxt, addend;
   logic [7:0] pp;
   // idx[1] picks the A nibble, idx[0] the B nibble, matching the step order
   mult_4x4 u_mult (
      .a(idx[1] ? a_q[7:4] : a_q[3:0]),
      .b(idx[0] ? b_q[7:4] : b_q[3:0]),
      .p(pp)
   );
   assign addend = {8'd0, pp} << step_shift(idx);
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         idx     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         product <= '0;
      end else begin
         state   <= state_nxt;
         idx     <= idx_nxt;
         a_q     <= a_nxt;
         b_q     <= b_nxt;
         product <= product_nxt;
      end
   end
   always_comb begin
      state_nxt   = state;
      idx_nxt     = idx;
      a_nxt       = a_q;
      b_nxt       = b_q;
      product_nxt = product;
      case (state)
         CALC: begin
            product_nxt = product + addend;
            idx_nxt     = idx + 2'd1;
            state_nxt   = idx == 2'd3 ? DONE : CALC;
         end
         default: if (start) begin
            a_nxt       = dataa;
            b_nxt       = datab;
            product_nxt = '0;
            idx_nxt     = '0;
`ifdef SEQ_MULT_ZERO_SKIP_EN
            state_nxt   = (dataa == '0 || datab == '0) ? DONE : CALC;
`else
            state_nxt   = CALC;
`endif
         end
      endcase
   end
   assign done       = state == DONE;
   assign busy       = state == CALC;
   assign disp_state = busy ? {1'b0, idx} : DISP_END;
endmodule
